// File: rtl/irq_pkt_wrctrl_if.sv
// Bundle of the interrupt-side and FIFO-side signals of the packet write
// controller. The master is the controller; the slave is the environment
// that presents interrupts and the FIFO and receives writes and clears.
interface irq_pkt_wrctrl_if #(
  parameter int NUM_IRQ = 16,
  parameter int ADDR_W  = 4,
  parameter int FLIT_W  = 16
);
  logic [ADDR_W-1:0]  core_address;
  logic [NUM_IRQ-1:0] irq_in;
  logic               fifo_full;
  logic               fifo_wr;
  logic [FLIT_W-1:0]  fifo_data;
  logic [NUM_IRQ-1:0] irq_clear;
  logic               busy;

  modport master (
    input  core_address, irq_in, fifo_full,
    output fifo_wr, fifo_data, irq_clear, busy
  );

  modport slave (
    output core_address, irq_in, fifo_full,
    input  fifo_wr, fifo_data, irq_clear, busy
  );
endinterface

// File: rtl/irq_pkt_wrctrl.sv
// Interrupt-to-packet write controller: picks one pending interrupt line,
// writes a header and a tail flit into the NI FIFO (stalling on full) and
// then pulses a one-hot clear for the chosen line.
//
// state | meaning
// IDLE  | waiting for a pending irq and a non-full FIFO
// HEAD  | header flit presented, written when FIFO not full
// TAIL  | tail flit presented, written when FIFO not full
// CLR   | one-cycle one-hot clear of the selected line
module irq_pkt_wrctrl #(
  parameter int NUM_IRQ   = 16,
  parameter int IRQ_IDX_W = 4,
  parameter int ADDR_W    = 4,
  parameter int FLIT_W    = 16,
  parameter bit RR_MODE   = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  irq_pkt_wrctrl_if.master bus
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_HEAD = 2'd1;
  localparam logic [1:0] S_TAIL = 2'd2;
  localparam logic [1:0] S_CLR  = 2'd3;

  logic [1:0]           state_q, state_d;
  logic [IRQ_IDX_W-1:0] sel_idx_q, sel_idx_d;
  logic [IRQ_IDX_W:0]   pend_cnt_q, pend_cnt_d;
  logic [IRQ_IDX_W-1:0] rr_ptr_q, rr_ptr_d;

  logic [IRQ_IDX_W-1:0] fix_idx, rr_lo, rr_hi, pick_idx;
  logic                 rr_hit;
  logic [IRQ_IDX_W:0]   pop_cnt;
  logic [FLIT_W-1:0]    head_flit, tail_flit;

  // Candidate selection: highest set line for fixed priority; for round-robin
  // the lowest set line at or above rr_ptr, falling back to the lowest set line.
  always_comb begin
    fix_idx = '0;
    rr_lo   = '0;
    rr_hi   = '0;
    rr_hit  = 1'b0;
    pop_cnt = '0;
    for (int i = 0; i < NUM_IRQ; i++) begin
      if (bus.irq_in[i]) begin
        fix_idx = IRQ_IDX_W'(i);
        pop_cnt = pop_cnt + (IRQ_IDX_W+1)'(1);
      end
    end
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (bus.irq_in[i]) begin
        rr_lo = IRQ_IDX_W'(i);
        if (IRQ_IDX_W'(i) >= rr_ptr_q) begin
          rr_hi  = IRQ_IDX_W'(i);
          rr_hit = 1'b1;
        end
      end
    end
    pick_idx = RR_MODE ? (rr_hit ? rr_hi : rr_lo) : fix_idx;
  end

  // Next-state logic; selection is latched only on the IDLE -> HEAD transition.
  always_comb begin
    state_d    = state_q;
    sel_idx_d  = sel_idx_q;
    pend_cnt_d = pend_cnt_q;
    rr_ptr_d   = rr_ptr_q;
    case (state_q)
      S_IDLE: begin
        if ((bus.irq_in != '0) && !bus.fifo_full) begin
          sel_idx_d  = pick_idx;
          pend_cnt_d = pop_cnt - (IRQ_IDX_W+1)'(1);
          state_d    = S_HEAD;
        end
      end
      S_HEAD: if (!bus.fifo_full) state_d = S_TAIL;
      S_TAIL: if (!bus.fifo_full) state_d = S_CLR;
      default: begin
        if (RR_MODE) begin
          rr_ptr_d = (sel_idx_q == IRQ_IDX_W'(NUM_IRQ - 1)) ? '0
                                                           : sel_idx_q + IRQ_IDX_W'(1);
        end
        state_d = S_IDLE;
      end
    endcase
  end

  // State and latched selection registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      sel_idx_q  <= '0;
      pend_cnt_q <= '0;
      rr_ptr_q   <= '0;
    end else begin
      state_q    <= state_d;
      sel_idx_q  <= sel_idx_d;
      pend_cnt_q <= pend_cnt_d;
      rr_ptr_q   <= rr_ptr_d;
    end
  end

  // Flit formats; built by field assignment so a zero-width pad is legal.
  always_comb begin
    head_flit                          = '0;
    head_flit[FLIT_W-1 -: 3]           = 3'b001;
    head_flit[ADDR_W+IRQ_IDX_W-1:0]    = {bus.core_address, sel_idx_q};
    tail_flit                          = '0;
    tail_flit[FLIT_W-1 -: 3]           = 3'b110;
    tail_flit[IRQ_IDX_W:0]             = pend_cnt_q;
  end

  // Outputs decoded from state; forced low while reset is asserted because
  // the state register only clears on the following edge.
  always_comb begin
    bus.fifo_wr   = 1'b0;
    bus.fifo_data = '0;
    bus.irq_clear = '0;
    bus.busy      = 1'b0;
    if (!rst) begin
      bus.busy = (state_q != S_IDLE);
      case (state_q)
        S_HEAD: begin
          bus.fifo_wr   = !bus.fifo_full;
          bus.fifo_data = head_flit;
        end
        S_TAIL: begin
          bus.fifo_wr   = !bus.fifo_full;
          bus.fifo_data = tail_flit;
        end
        S_CLR:   bus.irq_clear = NUM_IRQ'(1) << sel_idx_q;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_irq_pkt_wrctrl.sv
// Bench for irq_pkt_wrctrl: a fixed-priority and a round-robin instance see
// the same inputs; a packet-level reference model predicts both every cycle.
module tb_irq_pkt_wrctrl;
  localparam int N = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  irq_pkt_wrctrl_if #(.NUM_IRQ(N), .ADDR_W(4), .FLIT_W(16)) if0 ();
  irq_pkt_wrctrl_if #(.NUM_IRQ(N), .ADDR_W(4), .FLIT_W(16)) if1 ();

  irq_pkt_wrctrl #(.NUM_IRQ(N), .IRQ_IDX_W(4), .ADDR_W(4), .FLIT_W(16), .RR_MODE(1'b0))
    u_fix (.clk(clk), .rst(rst), .bus(if0));
  irq_pkt_wrctrl #(.NUM_IRQ(N), .IRQ_IDX_W(4), .ADDR_W(4), .FLIT_W(16), .RR_MODE(1'b1))
    u_rr  (.clk(clk), .rst(rst), .bus(if1));

  int total = 0;
  int bad   = 0;

  // Reference model per instance: packet phase (0 none, 1 header owed,
  // 2 tail owed, 3 clear owed), chosen line, pending count, rr pointer.
  int m_phase[2];
  int m_sel[2];
  int m_pend[2];
  int m_ptr[2];

  logic [3:0]  core;
  logic [33:0] obs0, obs1;

  function automatic logic [33:0] vec(input bit b, input bit w, input logic [15:0] c,
                                      input logic [15:0] d);
    return {b, w, c, d};
  endfunction

  function automatic int pick(input int m, input logic [15:0] irq, input int ptr);
    if (m == 0) begin
      for (int i = N - 1; i >= 0; i--) if (irq[i]) return i;
    end else begin
      for (int k = 0; k < N; k++) if (irq[(ptr + k) % N]) return (ptr + k) % N;
    end
    return 0;
  endfunction

  function automatic logic [33:0] model_out(input int m, input bit full, input bit r);
    logic [15:0] clr;
    if (r) return '0;
    case (m_phase[m])
      1: return vec(1'b1, !full, 16'h0, 16'(32'h2000 + (int'(core) * 16) + m_sel[m]));
      2: return vec(1'b1, !full, 16'h0, 16'(32'hC000 + m_pend[m]));
      3: begin
        clr = '0;
        clr[m_sel[m]] = 1'b1;
        return vec(1'b1, 1'b0, clr, 16'h0);
      end
      default: return '0;
    endcase
  endfunction

  task automatic model_update(input int m, input logic [15:0] irq, input bit full,
                              input bit r);
    if (r) begin
      m_phase[m] = 0; m_sel[m] = 0; m_pend[m] = 0; m_ptr[m] = 0;
    end else begin
      case (m_phase[m])
        0: if (irq != 0 && !full) begin
          m_sel[m]   = pick(m, irq, m_ptr[m]);
          m_pend[m]  = $countones(irq) - 1;
          m_phase[m] = 1;
        end
        1: if (!full) m_phase[m] = 2;
        2: if (!full) m_phase[m] = 3;
        default: begin
          if (m == 1) m_ptr[m] = (m_sel[m] + 1) % N;
          m_phase[m] = 0;
        end
      endcase
    end
  endtask

  task automatic chk(input string tag, input logic [33:0] got, input logic [33:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic step(input logic [15:0] irq, input bit full, input bit r);
    logic [33:0] e0, e1;
    @(negedge clk);
    rst = r;
    if0.irq_in = irq; if1.irq_in = irq;
    if0.fifo_full = full; if1.fifo_full = full;
    if0.core_address = core; if1.core_address = core;
    #1;
    obs0 = {if0.busy, if0.fifo_wr, if0.irq_clear, if0.fifo_data};
    obs1 = {if1.busy, if1.fifo_wr, if1.irq_clear, if1.fifo_data};
    e0 = model_out(0, full, r);
    e1 = model_out(1, full, r);
    chk("model_fix", obs0, e0);
    chk("model_rr", obs1, e1);
    @(posedge clk);
    model_update(0, irq, full, r);
    model_update(1, irq, full, r);
  endtask

  initial begin
    core = 4'd3;
    for (int m = 0; m < 2; m++) begin
      m_phase[m] = 0; m_sel[m] = 0; m_pend[m] = 0; m_ptr[m] = 0;
    end

    // reset with requests pending: outputs must stay low
    step(16'hFFFF, 1'b0, 1'b1);
    step(16'h8004, 1'b0, 1'b1);
    chk("rst_out_fix", obs0, '0);
    chk("rst_out_rr", obs1, '0);

    // fixed priority packet
    step(16'h8004, 1'b0, 1'b0);
    chk("t1_sel_idle", obs0, '0);
    step(16'h0000, 1'b0, 1'b0);
    chk("t1_head", obs0, vec(1, 1, 16'h0, 16'h203F));
    chk("t1_head_rr", obs1, vec(1, 1, 16'h0, 16'h2032));
    step(16'h0000, 1'b0, 1'b0);
    chk("t1_tail", obs0, vec(1, 1, 16'h0, 16'hC001));
    step(16'h0000, 1'b0, 1'b0);
    chk("t1_clr", obs0, vec(1, 0, 16'h8000, 16'h0));
    step(16'h0000, 1'b0, 1'b0);
    chk("t1_idle", obs0, '0);

    // round-robin fairness with requests held
    step(16'h0000, 1'b0, 1'b1);
    for (int k = 0; k < 12; k++) begin
      step(16'h0005, 1'b0, 1'b0);
      if (k == 1) chk("t2_head0", obs1, vec(1, 1, 16'h0, 16'h2030));
      if (k == 5) chk("t2_head1", obs1, vec(1, 1, 16'h0, 16'h2032));
      if (k == 9) chk("t2_head2", obs1, vec(1, 1, 16'h0, 16'h2030));
    end
    step(16'h0000, 1'b0, 1'b0);

    // backpressure while the header is presented
    step(16'h0010, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      step(16'h0000, 1'b1, 1'b0);
      chk("t3_stall", obs0, vec(1, 0, 16'h0, 16'h2034));
    end
    step(16'h0000, 1'b0, 1'b0);
    chk("t3_head", obs0, vec(1, 1, 16'h0, 16'h2034));
    step(16'h0000, 1'b0, 1'b0);
    chk("t3_tail", obs0, vec(1, 1, 16'h0, 16'hC000));
    step(16'h0000, 1'b0, 1'b0);
    chk("t3_clr", obs0, vec(1, 0, 16'h0010, 16'h0));
    step(16'h0000, 1'b0, 1'b0);

    // full FIFO in idle blocks selection
    for (int k = 0; k < 5; k++) begin
      step(16'h0001, 1'b1, 1'b0);
      chk("t4_blocked", obs0, '0);
    end
    step(16'h0001, 1'b0, 1'b0);
    step(16'h0000, 1'b0, 1'b0);
    chk("t4_head", obs0, vec(1, 1, 16'h0, 16'h2030));
    step(16'h0000, 1'b0, 1'b0);
    chk("t4_tail", obs0, vec(1, 1, 16'h0, 16'hC000));
    step(16'h0000, 1'b0, 1'b0);
    chk("t4_clr", obs0, vec(1, 0, 16'h0001, 16'h0));
    step(16'h0000, 1'b0, 1'b0);

    // request changes after selection are ignored
    step(16'h8000, 1'b0, 1'b0);
    step(16'h0002, 1'b0, 1'b0);
    chk("t5_head", obs0, vec(1, 1, 16'h0, 16'h203F));
    step(16'h0002, 1'b0, 1'b0);
    chk("t5_tail", obs0, vec(1, 1, 16'h0, 16'hC000));
    step(16'h0002, 1'b0, 1'b0);
    chk("t5_clr", obs0, vec(1, 0, 16'h8000, 16'h0));
    chk("t5_clr_rr", obs1, vec(1, 0, 16'h8000, 16'h0));
    step(16'h0000, 1'b0, 1'b0);

    // reset during tail aborts the packet and rewinds the rr pointer
    step(16'h0004, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) step(16'h0000, 1'b0, 1'b0);
    step(16'h0008, 1'b0, 1'b0);
    step(16'h0000, 1'b0, 1'b0);
    chk("t6_head", obs1, vec(1, 1, 16'h0, 16'h2033));
    step(16'h0000, 1'b0, 1'b1);
    chk("t6_rst_fix", obs0, '0);
    chk("t6_rst_rr", obs1, '0);
    step(16'h0000, 1'b0, 1'b0);
    chk("t6_no_clr", obs1, '0);
    step(16'h0011, 1'b0, 1'b0);
    step(16'h0000, 1'b0, 1'b0);
    chk("t6_rr_restart", obs1, vec(1, 1, 16'h0, 16'h2030));
    chk("t6_fix_head", obs0, vec(1, 1, 16'h0, 16'h2034));
    for (int k = 0; k < 3; k++) step(16'h0000, 1'b0, 1'b0);

    // randomized traffic against the model
    for (int k = 0; k < 3000; k++) begin
      logic [15:0] irq;
      bit full, r;
      irq  = ($urandom_range(0, 2) == 0) ? 16'h0 : 16'($urandom);
      if ($urandom_range(0, 3) == 0) irq = 16'h1 << $urandom_range(0, 15);
      full = ($urandom_range(0, 9) < 3);
      r    = ($urandom_range(0, 59) == 0);
      if ($urandom_range(0, 7) == 0) core = 4'($urandom);
      step(irq, full, r);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/irq_pkt_wrctrl.md
Name: irq_pkt_wrctrl

Overview:
Parametrised interrupt-to-packet write controller for the sensor network interface. It selects one pending interrupt line by fixed or round-robin priority and writes a header flit and a tail flit into the priority NI FIFO. It stalls on FIFO full without losing or corrupting flits. After the packet is written, it pulses a one-hot clear back to the interrupt source.

Parameters:
NUM_IRQ, 16, number of interrupt lines
IRQ_IDX_W, 4, width of interrupt index; must satisfy 2**IRQ_IDX_W >= NUM_IRQ
ADDR_W, 4, core address width
FLIT_W, 16, FIFO flit width; must satisfy FLIT_W >= 3+ADDR_W+IRQ_IDX_W and FLIT_W >= 4+IRQ_IDX_W
RR_MODE, 0, 0 = fixed priority (highest index wins), 1 = round-robin

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
core_address  in  ADDR_W  source core id placed in header
irq_in  in  NUM_IRQ  level interrupt requests
fifo_full  in  1  priority NI FIFO full
fifo_wr  out  1  FIFO write strobe
fifo_data  out  FLIT_W  flit to FIFO
irq_clear  out  NUM_IRQ  one-hot, one-cycle clear to the interrupt source
busy  out  1  high in any state except IDLE

Behaviour:
- Reset (sync): state=IDLE, rr_ptr=0, sel_idx=0, pend_cnt=0.
  - While rst is high, all outputs are 0: fifo_wr=0, fifo_data=0, irq_clear=0, busy=0.
- Outputs are combinational from state, latched registers and fifo_full.
- States: IDLE, HEAD, TAIL, CLR.
- IDLE:
  - If irq_in!=0 and !fifo_full: latch sel_idx, latch pend_cnt, go to HEAD.
  - Otherwise stay in IDLE.
  - Outputs are all 0.
- Selection:
  - RR_MODE=0: highest set index.
  - RR_MODE=1: lowest set index >= rr_ptr; if none, wrap and take the lowest set index.
- pend_cnt = popcount(irq_in) - 1 at selection. Width is IRQ_IDX_W+1.
- HEAD:
  - fifo_data = {3'b001, zero pad, core_address, sel_idx}.
  - fifo_wr = !fifo_full.
  - Advance to TAIL only in a cycle where fifo_full=0; otherwise hold state and data.
- TAIL:
  - fifo_data = {3'b110, pend_cnt zero-extended to FLIT_W-3}.
  - fifo_wr = !fifo_full.
  - Advance to CLR only when fifo_full=0.
- CLR:
  - irq_clear = one-hot(sel_idx) for exactly one cycle; fifo_wr=0; fifo_data=0.
  - If RR_MODE=1: rr_ptr <= (sel_idx==NUM_IRQ-1) ? 0 : sel_idx+1.
  - Go to IDLE.
- Latency: selection in cycle T gives header write at T+1, tail at T+2 and clear at T+3, when fifo_full=0 throughout. The minimum inter-packet spacing is 4 cycles.
- Selection is frozen once HEAD is entered. Changes on irq_in during HEAD/TAIL/CLR do not alter the flits or the cleared bit.
  - The latched line is cleared even if it has since dropped.
- fifo_full=1 in IDLE with a pending irq: no selection; rr_ptr is unchanged.
- A full FIFO never causes a flit to be dropped. fifo_wr is never high while fifo_full is high.
- rst mid-packet: next state is IDLE; no irq_clear is issued; rr_ptr returns to 0. The partial packet in the FIFO is the FIFO owner's concern.
- rr_ptr wraps from NUM_IRQ-1 to 0.

Test Plan:
1. Fixed priority: RR_MODE=0, core_address=3, irq_in=0x8004, fifo_full=0 -> wr at T+1 with data 0x203F; wr at T+2 with data 0xC001; irq_clear=0x8000 at T+3 only; busy high for T+1..T+3.
2. Round-robin fairness: RR_MODE=1, irq_in held at 0x0005 with no clearing -> successive headers 0x2030, 0x2032, 0x2030; rr_ptr follows 1, 3, 1.
3. Backpressure in HEAD: fifo_full=1 for 3 cycles from T+1 -> fifo_wr=0 for those cycles and fifo_data held at the header value. Header is written on the first non-full cycle, tail on the cycle after, clear one cycle later; no duplicate or missing flit.
4. Full in IDLE: irq_in=0x0001, fifo_full=1 for 5 cycles -> state stays IDLE, fifo_wr=0, irq_clear=0. Release fifo_full -> normal packet 0x2030 then 0xC000.
5. Input change mid-packet: select idx 15, then irq_in becomes 0x0002 during HEAD -> tail 0xC000 (pend_cnt from selection time); irq_clear=0x8000 at CLR.
6. Reset mid-packet: assert rst during TAIL -> next cycle IDLE; all outputs 0; no irq_clear pulse; the next packet restarts round-robin from rr_ptr=0.
